// File: rtl/pic_arb_pkg.sv
// Shared types and helpers for the interrupt claim/complete arbiter.
// Optional rotating priority: define PIC_ARB_ROUND_ROBIN_EN.
package pic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CLR   = 2'd2,
    SERVE = 2'd3
  } arb_state_e;

  localparam arb_state_e RST_STATE = IDLE;
  localparam logic       RST_REQ   = 1'b0;
  localparam logic       RST_CLR   = 1'b0;
  localparam logic       RST_BUSY  = 1'b0;

  // Minimum vector width able to index n sources.
  function automatic int vec_w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Priority encoder: first set bit of pend, searching upward
// from start and wrapping at N. start=0 gives fixed priority.
module pic_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  int           j;

  // Scan N positions starting at start; keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    rot   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j   = (int'(start) + i) % N;
      rot = pend >> j;
      if (!valid && rot[0]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/pic_arb.sv
// Interrupt claim/complete arbiter between PIC status bank and CPU.
// Optional rotating priority: define PIC_ARB_ROUND_ROBIN_EN.
module pic_arb
  import pic_arb_pkg::*;
#(
  parameter int PIC_INT_NUM = 16,
  parameter int VEC_W       = 4
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [PIC_INT_NUM-1:0] int_sta,
  input  logic [PIC_INT_NUM-1:0] int_msk,
  input  logic                   arb_en,
  output logic                   irq_req,
  output logic [VEC_W-1:0]       irq_vec,
  input  logic                   irq_ack,
  input  logic                   irq_done,
  output logic                   int_clr_en,
  output logic [PIC_INT_NUM-1:0] clr_ints,
  output logic                   busy
);

  localparam logic [PIC_INT_NUM-1:0] ONE = PIC_INT_NUM'(1);

  if (VEC_W < vec_w_of(PIC_INT_NUM)) begin : g_vec_w_chk
    $error("pic_arb: VEC_W too narrow for PIC_INT_NUM");
  end

  arb_state_e             state_q;
  arb_state_e             state_d;
  logic [VEC_W-1:0]       vec_q;
  logic [VEC_W-1:0]       vec_d;
  logic [PIC_INT_NUM-1:0] pend;
  logic [PIC_INT_NUM-1:0] vec_oh;
  logic                   cur_pend;
  logic                   win_vld;
  logic [VEC_W-1:0]       win_idx;
  logic [VEC_W-1:0]       start;

  assign pend     = int_sta & ~int_msk;
  assign vec_oh   = ONE << vec_q;
  assign cur_pend = |(pend & vec_oh);
  assign irq_vec  = vec_q;

`ifdef PIC_ARB_ROUND_ROBIN_EN
  localparam logic [VEC_W-1:0] LAST = VEC_W'(PIC_INT_NUM - 1);

  logic [VEC_W-1:0] last_q;

  // Last-grant pointer, captured as the claim is accepted.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      last_q <= LAST;
    end else if (state_q == REQ && irq_ack) begin
      last_q <= vec_q;
    end
  end

  assign start = (last_q == LAST) ? '0 : last_q + 1'b1;
`else
  assign start = '0;
`endif

  pic_prio_enc #(
    .N (PIC_INT_NUM),
    .W (VEC_W)
  ) u_enc (
    .pend  (pend),
    .start (start),
    .valid (win_vld),
    .idx   (win_idx)
  );

  // State and frozen vector registers.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= RST_STATE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  // Next-state logic and Moore outputs decoded from state.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    irq_req    = RST_REQ;
    int_clr_en = RST_CLR;
    clr_ints   = '0;
    busy       = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = RST_BUSY;
        if (arb_en && win_vld) begin
          vec_d   = win_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        irq_req = 1'b1;
        if (irq_ack) begin
          state_d = CLR;
        end else if (!cur_pend) begin
          state_d = IDLE;
        end
      end
      CLR: begin
        int_clr_en = 1'b1;
        clr_ints   = vec_oh;
        state_d    = SERVE;
      end
      SERVE: begin
        if (irq_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pic_arb.sv
// Scoreboard bench for pic_arb: stimulus queues expected
// request vectors and clear masks, a negedge monitor checks them.
module tb_pic_arb;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [15:0] int_sta = '0;
  logic [15:0] int_msk = '0;
  logic        arb_en = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic        irq_req;
  logic [3:0]  irq_vec;
  logic        int_clr_en;
  logic [15:0] clr_ints;
  logic        busy;

  typedef struct packed {
    logic        is_clr;
    logic [15:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic req_q = 1'b0;
  int   seq[4];
  int   cnt;

  pic_arb #(
    .PIC_INT_NUM (16),
    .VEC_W       (4)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .int_sta    (int_sta),
    .int_msk    (int_msk),
    .arb_en     (arb_en),
    .irq_req    (irq_req),
    .irq_vec    (irq_vec),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .int_clr_en (int_clr_en),
    .clr_ints   (clr_ints),
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic push_req(input int v);
    exp_q.push_back('{1'b0, 16'(v)});
  endtask

  task automatic push_clr(input logic [15:0] m);
    exp_q.push_back('{1'b1, m});
  endtask

  task automatic pop_chk(input logic kind, input logic [15:0] v,
                         input string nm);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event got 0x%0h want none",
               nm, v);
    end else begin
      e = exp_q.pop_front();
      if (e.is_clr !== kind || e.val !== v) begin
        fails++;
        $display("FAIL %s: got kind %0d 0x%0h want kind %0d 0x%0h",
                 nm, kind, v, e.is_clr, e.val);
      end
    end
  endtask

  // Monitor: every rising request and every clear strobe
  // must match the head of the expectation queue.
  always @(negedge pclk) begin
    if (presetn) begin
      if (irq_req && !req_q) pop_chk(1'b0, 16'(irq_vec), "req_vec");
      if (int_clr_en) pop_chk(1'b1, clr_ints, "clr_ints");
    end
    req_q = irq_req;
  end

  task automatic wait_req(input string nm);
    int c;
    c = 0;
    while (!irq_req && c < 10) begin
      step(1);
      c++;
    end
    chk({"req_seen_", nm}, 16'(irq_req), 16'd1);
  endtask

  task automatic serve(input int v, input logic [15:0] sta_after);
    irq_ack = 1'b1;
    push_clr(16'd1 << v);
    step(1);
    irq_ack = 1'b0;
    chk("clr_en_hi", 16'(int_clr_en), 16'd1);
    int_sta = sta_after;
    step(1);
    chk("serve_busy", 16'(busy), 16'd1);
    irq_done = 1'b1;
    step(1);
    irq_done = 1'b0;
    chk("idle_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PIC_ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 2, 0};
`else
    seq = '{0, 0, 0, 0};
`endif
    step(2);
    chk("rst_req", 16'(irq_req), 16'd0);
    chk("rst_vec", 16'(irq_vec), 16'd0);
    chk("rst_clr_en", 16'(int_clr_en), 16'd0);
    chk("rst_clr_ints", clr_ints, 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    presetn = 1'b1;

    // single source
    int_sta = 16'h0010;
    arb_en  = 1'b1;
    push_req(4);
    step(1);
    chk("t1_req", 16'(irq_req), 16'd1);
    chk("t1_vec", 16'(irq_vec), 16'd4);
    irq_ack = 1'b1;
    push_clr(16'h0010);
    step(1);
    irq_ack = 1'b0;
    chk("t1_clr_en", 16'(int_clr_en), 16'd1);
    chk("t1_clr_req", 16'(irq_req), 16'd0);
    int_sta = '0;
    step(1);
    chk("t1_clr_1cyc", 16'(int_clr_en), 16'd0);
    step(3);
    chk("t1_busy", 16'(busy), 16'd1);
    irq_done = 1'b1;
    step(1);
    irq_done = 1'b0;
    chk("t1_done", 16'(busy), 16'd0);

    // priority and freeze
    int_sta = 16'h0300;
    push_req(8);
    step(1);
    chk("t2_vec8", 16'(irq_vec), 16'd8);
    int_sta = 16'h0304;
    step(2);
    chk("t2_frozen_req", 16'(irq_req), 16'd1);
    chk("t2_frozen_vec", 16'(irq_vec), 16'd8);
    irq_ack = 1'b1;
    push_clr(16'h0100);
    step(1);
    irq_ack = 1'b0;
    chk("t2_clr_en", 16'(int_clr_en), 16'd1);
    int_sta = 16'h0004;
    step(1);
    irq_done = 1'b1;
    push_req(2);
    step(1);
    irq_done = 1'b0;
    chk("t2_gap", 16'(irq_req), 16'd0);
    step(1);
    chk("t2_vec2", 16'(irq_vec), 16'd2);
    serve(2, 16'h0000);

    // withdraw
    int_sta = 16'h0020;
    push_req(5);
    step(1);
    chk("t3_vec5", 16'(irq_vec), 16'd5);
    int_msk = 16'h0020;
    step(1);
    chk("t3_wd_req", 16'(irq_req), 16'd0);
    chk("t3_wd_busy", 16'(busy), 16'd0);
    step(2);
    chk("t3_wd_noclr", 16'(int_clr_en), 16'd0);
    int_msk = '0;
    push_req(5);
    step(1);
    chk("t3_req2", 16'(irq_req), 16'd1);
    int_msk = 16'h0020;
    irq_ack = 1'b1;
    push_clr(16'h0020);
    step(1);
    irq_ack = 1'b0;
    chk("t3_ackwin", 16'(int_clr_en), 16'd1);
    chk("t3_ackmask", clr_ints, 16'h0020);
    int_msk = '0;
    int_sta = '0;
    step(1);
    irq_done = 1'b1;
    step(1);
    irq_done = 1'b0;

    // reset mid-operation
    int_sta = 16'h0008;
    push_req(3);
    step(1);
    irq_ack = 1'b1;
    push_clr(16'h0008);
    step(1);
    irq_ack = 1'b0;
    int_sta = '0;
    step(1);
    chk("t4_serve", 16'(busy), 16'd1);
    presetn = 1'b0;
    step(1);
    presetn = 1'b1;
    chk("t4_req", 16'(irq_req), 16'd0);
    chk("t4_vec", 16'(irq_vec), 16'd0);
    chk("t4_clr_en", 16'(int_clr_en), 16'd0);
    chk("t4_clr_ints", clr_ints, 16'd0);
    chk("t4_busy", 16'(busy), 16'd0);
    step(2);
    chk("t4_noclr", 16'(int_clr_en), 16'd0);

    // masking, then enable off, with stray ack/done
    int_sta = 16'hFFFF;
    int_msk = 16'hFFFF;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      irq_ack  = (i == 5);
      irq_done = (i == 10);
      step(1);
      if (irq_req) cnt++;
    end
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    chk("t5_masked", 16'(cnt), 16'd0);
    chk("t5_masked_busy", 16'(busy), 16'd0);
    int_msk = '0;
    arb_en  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      irq_ack  = (i == 3);
      irq_done = (i == 7);
      step(1);
      if (irq_req || busy) cnt++;
    end
    irq_ack  = 1'b0;
    irq_done = 1'b0;
    chk("t5_disabled", 16'(cnt), 16'd0);

    // level sources 0..2 held: grant sequence
    int_sta = 16'h0007;
    arb_en  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_req(seq[k]);
      wait_req($sformatf("rr%0d", k));
      chk($sformatf("rr_vec%0d", k), 16'(irq_vec), 16'(seq[k]));
      if (k == 3) arb_en = 1'b0;
      serve(seq[k], 16'h0007);
    end

    step(3);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
